// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
// Holds the FSM state encoding, address width and stack pointer reset value.
package data_mem_ctrl_pkg;

   localparam int MEM_AW = 11;

   typedef logic [MEM_AW-1:0] maddr_t;

   localparam maddr_t SP_RESET = 11'h7FF;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      PC_LO,
      POP_LO,
      POP_HI
   } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request, data-memory and result signals of the MEM-stage controller.
// The slave side is the controller; the master side is the pipeline and memory.
interface data_mem_ctrl_if;
   import data_mem_ctrl_pkg::*;

   logic          memRead;
   logic          memWrite;
   logic          push;
   logic          pop;
   logic          pc_push;
   logic          pc_pop;
   logic [15:0]   addr;
   logic [15:0]   wdata;
   logic [31:0]   pc_in;
   logic [15:0]   mem_rdata;
   maddr_t        mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [15:0]   rdata_out;
   logic          rdata_valid;
   logic [31:0]   pc_out;
   logic          pc_valid;
   logic          stall;
   maddr_t        sp;
   logic          stack_err;

   modport master (
      output memRead, memWrite, push, pop, pc_push, pc_pop,
      output addr, wdata, pc_in, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      input  rdata_out, rdata_valid, pc_out, pc_valid, stall, sp, stack_err
   );

   modport slave (
      input  memRead, memWrite, push, pop, pc_push, pc_pop,
      input  addr, wdata, pc_in, mem_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re,
      output rdata_out, rdata_valid, pc_out, pc_valid, stall, sp, stack_err
   );

endinterface

// File: rtl/data_mem_ctrl_sp_reg.sv
// Descending stack pointer with +/-1 and +/-2 updates, wrapping modulo 2048.
// Updates on the next edge; exposes neighbour addresses and full/empty compares.
module data_mem_ctrl_sp_reg
   import data_mem_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   inc1,
   input  logic   dec1,
   input  logic   inc2,
   input  logic   dec2,
   output maddr_t sp,
   output maddr_t sp_p1,
   output maddr_t sp_p2,
   output maddr_t sp_m1,
   output logic   empty1,
   output logic   empty2,
   output logic   full1,
   output logic   full2
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= SP_RESET;
      end else if (inc1) begin
         sp <= sp + maddr_t'(1);
      end else if (dec1) begin
         sp <= sp - maddr_t'(1);
      end else if (inc2) begin
         sp <= sp + maddr_t'(2);
      end else if (dec2) begin
         sp <= sp - maddr_t'(2);
      end
   end

   assign sp_p1  = sp + maddr_t'(1);
   assign sp_p2  = sp + maddr_t'(2);
   assign sp_m1  = sp - maddr_t'(1);

   // empty: fewer than one (or two) words on the stack; full: no room for one (or two)
   assign empty1 = (sp == 11'h7FF);
   assign empty2 = (sp >= 11'h7FE);
   assign full1  = (sp == 11'h000);
   assign full2  = (sp <= 11'h001);

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage controller arbitrating loads/stores, stack and 32-bit PC save/restore onto one memory port.
// Store/push take 0 extra cycles, load/pop/pc_push 1, pc_pop 2; stall holds the pipeline, no other backpressure.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   data_mem_ctrl_if.slave bus
);

   state_t       state;
   state_t       state_nxt;
   logic [15:0]  pc_lo_q;
   logic [15:0]  low_q;
   logic [15:0]  rdata_q;
   logic [31:0]  pc_q;

   logic         pc_lo_ld;
   logic         low_ld;
   logic         rd_ld;
   logic         pc_ld;
   logic         inc1, dec1, inc2, dec2;
   logic         mem_we, mem_re, stack_err;
   maddr_t       mem_addr;
   logic [15:0]  mem_wdata;

   maddr_t       sp, sp_p1, sp_p2, sp_m1;
   logic         empty1, empty2, full1, full2;
   logic         unused_addr_hi;

   assign unused_addr_hi = ^bus.addr[15:11];

   data_mem_ctrl_sp_reg sp_reg (
      .clk    (clk),
      .rst    (rst),
      .inc1   (inc1),
      .dec1   (dec1),
      .inc2   (inc2),
      .dec2   (dec2),
      .sp     (sp),
      .sp_p1  (sp_p1),
      .sp_p2  (sp_p2),
      .sp_m1  (sp_m1),
      .empty1 (empty1),
      .empty2 (empty2),
      .full1  (full1),
      .full2  (full2)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pc_lo_q <= '0;
         low_q   <= '0;
         rdata_q <= '0;
         pc_q    <= '0;
      end else begin
         state <= state_nxt;
         if (pc_lo_ld) pc_lo_q <= bus.pc_in[15:0];
         if (low_ld)   low_q   <= bus.mem_rdata;
         if (rd_ld)    rdata_q <= bus.mem_rdata;
         if (pc_ld)    pc_q    <= {bus.mem_rdata, low_q};
      end
   end

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stack_err = 1'b0;
      pc_lo_ld  = 1'b0;
      low_ld    = 1'b0;
      rd_ld     = 1'b0;
      pc_ld     = 1'b0;
      inc1      = 1'b0;
      dec1      = 1'b0;
      inc2      = 1'b0;
      dec2      = 1'b0;
      // Gating on rst keeps the port quiet while reset is held, even in IDLE.
      if (rst) begin
         case (state)
            IDLE: begin
               if (bus.pc_pop) begin
                  if (empty2) begin
                     stack_err = 1'b1;
                  end else begin
                     mem_re    = 1'b1;
                     mem_addr  = sp_p1;
                     state_nxt = POP_LO;
                  end
               end else if (bus.pc_push) begin
                  if (full2) begin
                     stack_err = 1'b1;
                  end else begin
                     mem_we    = 1'b1;
                     mem_addr  = sp;
                     mem_wdata = bus.pc_in[31:16];
                     pc_lo_ld  = 1'b1;
                     state_nxt = PC_LO;
                  end
               end else if (bus.pop) begin
                  if (empty1) begin
                     stack_err = 1'b1;
                  end else begin
                     mem_re    = 1'b1;
                     mem_addr  = sp_p1;
                     inc1      = 1'b1;
                     state_nxt = RD_WAIT;
                  end
               end else if (bus.push) begin
                  if (full1) begin
                     stack_err = 1'b1;
                  end else begin
                     mem_we    = 1'b1;
                     mem_addr  = sp;
                     mem_wdata = bus.wdata;
                     dec1      = 1'b1;
                  end
               end else if (bus.memRead) begin
                  mem_re    = 1'b1;
                  mem_addr  = bus.addr[MEM_AW-1:0];
                  state_nxt = RD_WAIT;
               end else if (bus.memWrite) begin
                  mem_we    = 1'b1;
                  mem_addr  = bus.addr[MEM_AW-1:0];
                  mem_wdata = bus.wdata;
               end
            end
            RD_WAIT: begin
               rd_ld     = 1'b1;
               state_nxt = IDLE;
            end
            PC_LO: begin
               // sp has not moved yet, so the low half goes one below the high half
               mem_we    = 1'b1;
               mem_addr  = sp_m1;
               mem_wdata = pc_lo_q;
               dec2      = 1'b1;
               state_nxt = IDLE;
            end
            POP_LO: begin
               low_ld    = 1'b1;
               mem_re    = 1'b1;
               mem_addr  = sp_p2;
               state_nxt = POP_HI;
            end
            POP_HI: begin
               pc_ld     = 1'b1;
               inc2      = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.mem_we      = mem_we;
   assign bus.mem_re      = mem_re;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;
   assign bus.stack_err   = stack_err;
   assign bus.stall       = (state != IDLE);
   assign bus.sp          = sp;
   assign bus.rdata_valid = (state == RD_WAIT);
   assign bus.rdata_out   = (state == RD_WAIT) ? bus.mem_rdata : rdata_q;
   assign bus.pc_valid    = (state == POP_HI);
   assign bus.pc_out      = (state == POP_HI) ? {bus.mem_rdata, low_q} : pc_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus random request mixes against a stack/memory model.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   localparam logic [5:0] R_PCPOP  = 6'b100000;
   localparam logic [5:0] R_PCPUSH = 6'b010000;
   localparam logic [5:0] R_POP    = 6'b001000;
   localparam logic [5:0] R_PUSH   = 6'b000100;
   localparam logic [5:0] R_RD     = 6'b000010;
   localparam logic [5:0] R_WR     = 6'b000001;
   localparam logic [5:0] R_NONE   = 6'b000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   data_mem_ctrl_if bus ();

   data_mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Synchronous memory the controller talks to
   logic [15:0] dmem [0:2047];
   always @(posedge clk) begin
      if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr];
   end

   // Reference model: word array plus a descending stack pointer
   logic [15:0] ref_mem [0:2047];
   logic [10:0] ref_sp;
   logic [15:0] ref_rdata;
   logic [31:0] ref_pc;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_req();
      {bus.pc_pop, bus.pc_push, bus.pop, bus.push, bus.memRead, bus.memWrite} = R_NONE;
      bus.addr  = '0;
      bus.wdata = '0;
      bus.pc_in = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_req();
      bus.memWrite = 1'b1;
      bus.addr     = 16'h0123;
      bus.wdata    = 16'hA5A5;
      rst = 1'b0;
      #2;
      chk1 ("rst_stall",  bus.stall, 1'b0);
      chk32("rst_sp",     32'(bus.sp), 32'h7FF);
      chk1 ("rst_we",     bus.mem_we, 1'b0);
      chk1 ("rst_re",     bus.mem_re, 1'b0);
      chk1 ("rst_rvld",   bus.rdata_valid, 1'b0);
      chk1 ("rst_pvld",   bus.pc_valid, 1'b0);
      chk1 ("rst_err",    bus.stack_err, 1'b0);
      chk32("rst_maddr",  32'(bus.mem_addr), 32'h0);
      chk32("rst_mwdata", 32'(bus.mem_wdata), 32'h0);
      chk32("rst_rdata",  32'(bus.rdata_out), 32'h0);
      chk32("rst_pcout",  bus.pc_out, 32'h0);
      clr_req();
      step();
      rst       = 1'b1;
      ref_sp    = 11'h7FF;
      ref_rdata = '0;
      ref_pc    = '0;
   endtask

   // One granted operation, checked cycle by cycle; entered and left one time unit after an edge.
   task automatic run_op(input logic [5:0] req, input logic [15:0] a, input logic [15:0] d,
                         input logic [31:0] pc);
      logic [10:0] s1, s2, sm1, la;
      logic        err;
      s1  = ref_sp + 11'd1;
      s2  = ref_sp + 11'd2;
      sm1 = ref_sp - 11'd1;
      la  = a[10:0];
      err = (req[5] && ref_sp >= 11'h7FE) ||
            (req[5] == 1'b0 && req[4] && ref_sp <= 11'h001) ||
            (req[5:4] == 2'b00 && req[3] && ref_sp == 11'h7FF) ||
            (req[5:3] == 3'b000 && req[2] && ref_sp == 11'h000);
      {bus.pc_pop, bus.pc_push, bus.pop, bus.push, bus.memRead, bus.memWrite} = req;
      bus.addr  = a;
      bus.wdata = d;
      bus.pc_in = pc;
      #4;
      chk1 ("n_stall",  bus.stall, 1'b0);
      chk32("n_sp",     32'(bus.sp), 32'(ref_sp));
      chk1 ("n_rvld",   bus.rdata_valid, 1'b0);
      chk1 ("n_pvld",   bus.pc_valid, 1'b0);
      chk32("n_rhold",  32'(bus.rdata_out), 32'(ref_rdata));
      chk32("n_phold",  bus.pc_out, ref_pc);
      chk1 ("n_err",    bus.stack_err, err);
      chk1 ("n_excl",   bus.mem_we & bus.mem_re, 1'b0);
      if (err) begin
         chk1("err_we", bus.mem_we, 1'b0);
         chk1("err_re", bus.mem_re, 1'b0);
      end else if (req[5]) begin
         chk1 ("pcpop_re0",   bus.mem_re, 1'b1);
         chk32("pcpop_a0",    32'(bus.mem_addr), 32'(s1));
         step(); clr_req(); bus.pc_in = $urandom; #4;
         chk1 ("pcpop_st1",   bus.stall, 1'b1);
         chk1 ("pcpop_re1",   bus.mem_re, 1'b1);
         chk1 ("pcpop_we1",   bus.mem_we, 1'b0);
         chk32("pcpop_a1",    32'(bus.mem_addr), 32'(s2));
         step(); #4;
         ref_pc = {ref_mem[s2], ref_mem[s1]};
         chk1 ("pcpop_st2",   bus.stall, 1'b1);
         chk1 ("pcpop_pvld",  bus.pc_valid, 1'b1);
         chk32("pcpop_pc",    bus.pc_out, ref_pc);
         chk1 ("pcpop_acc2",  bus.mem_we | bus.mem_re, 1'b0);
         ref_sp = s2;
      end else if (req[4]) begin
         chk1 ("pcpush_we0",  bus.mem_we, 1'b1);
         chk32("pcpush_a0",   32'(bus.mem_addr), 32'(ref_sp));
         chk32("pcpush_d0",   32'(bus.mem_wdata), 32'(pc[31:16]));
         ref_mem[ref_sp] = pc[31:16];
         step(); clr_req(); bus.pc_in = $urandom; #4;
         chk1 ("pcpush_st1",  bus.stall, 1'b1);
         chk1 ("pcpush_we1",  bus.mem_we, 1'b1);
         chk1 ("pcpush_re1",  bus.mem_re, 1'b0);
         chk32("pcpush_a1",   32'(bus.mem_addr), 32'(sm1));
         chk32("pcpush_d1",   32'(bus.mem_wdata), 32'(pc[15:0]));
         ref_mem[sm1] = pc[15:0];
         ref_sp = ref_sp - 11'd2;
      end else if (req[3]) begin
         chk1 ("pop_re",      bus.mem_re, 1'b1);
         chk32("pop_a",       32'(bus.mem_addr), 32'(s1));
         step(); clr_req(); #4;
         ref_rdata = ref_mem[s1];
         chk1 ("pop_st",      bus.stall, 1'b1);
         chk1 ("pop_rvld",    bus.rdata_valid, 1'b1);
         chk32("pop_data",    32'(bus.rdata_out), 32'(ref_rdata));
         chk1 ("pop_acc1",    bus.mem_we | bus.mem_re, 1'b0);
         ref_sp = s1;
      end else if (req[2]) begin
         chk1 ("push_we",     bus.mem_we, 1'b1);
         chk32("push_a",      32'(bus.mem_addr), 32'(ref_sp));
         chk32("push_d",      32'(bus.mem_wdata), 32'(d));
         ref_mem[ref_sp] = d;
         ref_sp = sm1;
      end else if (req[1]) begin
         chk1 ("ld_re",       bus.mem_re, 1'b1);
         chk32("ld_a",        32'(bus.mem_addr), 32'(la));
         step(); clr_req(); #4;
         ref_rdata = ref_mem[la];
         chk1 ("ld_st",       bus.stall, 1'b1);
         chk1 ("ld_rvld",     bus.rdata_valid, 1'b1);
         chk32("ld_data",     32'(bus.rdata_out), 32'(ref_rdata));
      end else if (req[0]) begin
         chk1 ("st_we",       bus.mem_we, 1'b1);
         chk1 ("st_re",       bus.mem_re, 1'b0);
         chk32("st_a",        32'(bus.mem_addr), 32'(la));
         chk32("st_d",        32'(bus.mem_wdata), 32'(d));
         ref_mem[la] = d;
      end else begin
         chk1("nop_acc", bus.mem_we | bus.mem_re, 1'b0);
      end
      step();
      clr_req();
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         dmem[i]    = '0;
         ref_mem[i] = '0;
      end
      bus.mem_rdata = '0;
      ref_sp    = 11'h7FF;
      ref_rdata = '0;
      ref_pc    = '0;
      clr_req();
      @(posedge clk);
      #1;
      do_reset();

      // Underflow straight after reset, then store/load round trip
      run_op(R_POP, 16'h0, 16'h0, 32'h0);
      run_op(R_WR,  16'h0010, 16'hBEEF, 32'h0);
      run_op(R_RD,  16'h0010, 16'h0, 32'h0);

      // Stack LIFO order
      run_op(R_PUSH, 16'h0, 16'h1234, 32'h0);
      run_op(R_PUSH, 16'h0, 16'h5678, 32'h0);
      run_op(R_POP,  16'h0, 16'h0, 32'h0);
      run_op(R_POP,  16'h0, 16'h0, 32'h0);

      // PC save/restore
      run_op(R_PCPUSH, 16'h0, 16'h0, 32'hCAFE_0042);
      run_op(R_PCPOP,  16'h0, 16'h0, 32'h0);

      // pc_pop beats a concurrent store; the store must not reach memory
      run_op(R_PCPUSH, 16'h0, 16'h0, 32'h1111_2222);
      run_op(R_PCPOP | R_WR, 16'h0020, 16'hDEAD, 32'h0);
      run_op(R_RD, 16'h0020, 16'h0, 32'h0);

      // pc_pop needs two words on the stack
      run_op(R_PUSH,  16'h0, 16'h00AA, 32'h0);
      run_op(R_PCPOP, 16'h0, 16'h0, 32'h0);
      run_op(R_POP,   16'h0, 16'h0, 32'h0);

      // Reset while in POP_HI abandons the restore
      run_op(R_PCPUSH, 16'h0, 16'h0, 32'h1357_9BDF);
      bus.pc_pop = 1'b1;
      #4;
      chk1("mid_re0", bus.mem_re, 1'b1);
      step(); clr_req(); #4;
      chk1("mid_re1", bus.mem_re, 1'b1);
      step();
      rst = 1'b0;
      #1;
      chk1 ("mid_pvld",  bus.pc_valid, 1'b0);
      chk1 ("mid_stall", bus.stall, 1'b0);
      chk32("mid_sp",    32'(bus.sp), 32'h7FF);
      chk32("mid_pcout", bus.pc_out, 32'h0);
      chk1 ("mid_acc",   bus.mem_we | bus.mem_re, 1'b0);
      step();
      rst       = 1'b1;
      ref_sp    = 11'h7FF;
      ref_rdata = '0;
      ref_pc    = '0;
      run_op(R_NONE,  16'h0, 16'h0, 32'h0);
      run_op(R_PCPOP, 16'h0, 16'h0, 32'h0);

      // Random request mixes, including simultaneous requests
      for (int i = 0; i < 400; i++) begin
         logic [5:0] rq;
         rq = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
         run_op(rq, {5'($urandom), 7'd0, 4'($urandom)}, 16'($urandom), $urandom);
      end

      // Fill the stack to the bottom and probe the overflow boundaries
      while (ref_sp != 11'h000) run_op(R_PUSH, 16'h0, 16'($urandom), 32'h0);
      run_op(R_PUSH,   16'h0, 16'h7777, 32'h0);
      run_op(R_PCPUSH, 16'h0, 16'h0, 32'h8888_9999);
      run_op(R_POP,    16'h0, 16'h0, 32'h0);
      run_op(R_PCPUSH, 16'h0, 16'h0, 32'h8888_9999);
      run_op(R_PUSH,   16'h0, 16'h4444, 32'h0);
      run_op(R_PCPOP,  16'h0, 16'h0, 32'h0);
      do_reset();
      run_op(R_POP, 16'h0, 16'h0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
